// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and constants for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_MFHI  = 4'd12;
    localparam logic [3:0] OP_MFLO  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Sliced to the datapath width by users; covers WIDTH up to 64.
    localparam logic [63:0] DIV_BY_ZERO_LO = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring unsigned divide.
// {hi,lo} is one 2*WIDTH shift register: product for MULTU, {remainder,quotient} for DIVU.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic                 busy_q, busy_d;
    logic                 fin_q, fin_d;
    logic                 div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   step_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       shl_s;
    logic [WIDTH:0]       diff_s;

    // One iteration of multiply (add then shift right) or divide (shift left then trial subtract).
    always_comb begin
        sum_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        shl_s  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff_s = shl_s - {1'b0, b_q};
        if (div_q) begin
            if (diff_s[WIDTH]) begin
                step_s = {shl_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            end else begin
                step_s = {diff_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_s = {sum_s, p_q[WIDTH-1:1]};
        end
    end

    // Load on start, iterate while busy, raise fin for one cycle after the last iteration.
    always_comb begin
        busy_d = busy_q;
        fin_d  = 1'b0;
        div_d  = div_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = {CNT_W{1'b0}};
            a_d    = A;
            b_d    = B;
            p_d    = {{WIDTH{1'b0}}, (is_div ? A : B)};
        end else if (busy_q) begin
            p_d   = step_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
                fin_d  = 1'b1;
                cnt_d  = {CNT_W{1'b0}};
                if (div_q && (b_q == {WIDTH{1'b0}})) begin
                    p_d = {a_q, DIV_BY_ZERO_LO[WIDTH-1:0]};
                end else begin
                    p_d = step_s;
                end
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            p_q    <= {(2*WIDTH){1'b0}};
        end else begin
            busy_q <= busy_d;
            fin_q  <= fin_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
        end
    end

    assign busy = busy_q;
    assign fin  = fin_q;
    assign hi   = p_q[2*WIDTH-1:WIDTH];
    assign lo   = p_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle ops through a two-register pipe, MULTU/DIVU via muldiv_iter.
// Single-cycle results appear two edges after the op is presented, one per cycle back to back.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int OP_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OP_W-1:0]    ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               Overflow,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO
);

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 v1_q, v1_d;
    logic [OP_W-1:0]      op1_q, op1_d;
    logic [WIDTH-1:0]     a1_q, a1_d;
    logic [WIDTH-1:0]     b1_q, b1_d;
    logic [SHAMT_W-1:0]   sh1_q, sh1_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 accept_s;
    logic                 md_start_s;
    logic                 md_is_div_s;
    logic                 md_busy_s;
    logic                 md_fin_s;
    logic [WIDTH-1:0]     md_hi_s;
    logic [WIDTH-1:0]     md_lo_s;
    logic [WIDTH-1:0]     add_s;
    logic [WIDTH-1:0]     sub_s;
    logic [WIDTH-1:0]     sra_s;
    logic                 slt_s;
    logic [WIDTH-1:0]     alu_s;
    logic                 alu_ovf_s;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (reset),
        .start  (md_start_s),
        .is_div (md_is_div_s),
        .A      (A),
        .B      (B),
        .busy   (md_busy_s),
        .fin    (md_fin_s),
        .hi     (md_hi_s),
        .lo     (md_lo_s)
    );

    // Handshake and FSM next state; ready drops for the whole multi-cycle op.
    always_comb begin
        accept_s    = start && ready_q && !md_busy_s;
        md_is_div_s = (ALUOperation == OP_DIVU);
        md_start_s  = accept_s && ((ALUOperation == OP_MULTU) || md_is_div_s);
        case (state_q)
            ST_IDLE: begin
                if (md_start_s) begin
                    state_d = md_is_div_s ? ST_DIV : ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_fin_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        v1_d    = accept_s && !md_start_s;
        if (accept_s) begin
            op1_d = ALUOperation;
            a1_d  = A;
            b1_d  = B;
            sh1_d = shamt;
        end else begin
            op1_d = op1_q;
            a1_d  = a1_q;
            b1_d  = b1_q;
            sh1_d = sh1_q;
        end
    end

    // Single-cycle datapath on the operands captured at accept.
    always_comb begin
        add_s     = a1_q + b1_q;
        sub_s     = a1_q - b1_q;
        sra_s     = $unsigned($signed(a1_q) >>> sh1_q);
        slt_s     = ($signed(a1_q) < $signed(b1_q));
        alu_ovf_s = 1'b0;
        case (op1_q)
            OP_AND:  alu_s = a1_q & b1_q;
            OP_OR:   alu_s = a1_q | b1_q;
            OP_NOR:  alu_s = ~(a1_q | b1_q);
            OP_ADD: begin
                alu_s     = add_s;
                alu_ovf_s = (a1_q[WIDTH-1] == b1_q[WIDTH-1]) && (add_s[WIDTH-1] != a1_q[WIDTH-1]);
            end
            OP_SLL:  alu_s = a1_q << sh1_q;
            OP_SRL:  alu_s = a1_q >> sh1_q;
            OP_SUB: begin
                alu_s     = sub_s;
                alu_ovf_s = (a1_q[WIDTH-1] != b1_q[WIDTH-1]) && (sub_s[WIDTH-1] != a1_q[WIDTH-1]);
            end
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_LUI:  alu_s = {b1_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SRA:  alu_s = sra_s;
            OP_MFHI: alu_s = hi_q;
            OP_MFLO: alu_s = lo_q;
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Result registers: a multi-cycle completion and a single-cycle result never land together.
    always_comb begin
        done_d = 1'b0;
        res_d  = res_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (md_fin_s) begin
            done_d = 1'b1;
            res_d  = md_lo_s;
            zero_d = (md_lo_s == {WIDTH{1'b0}});
            ovf_d  = 1'b0;
            hi_d   = md_hi_s;
            lo_d   = md_lo_s;
        end else if (v1_q) begin
            done_d = 1'b1;
            res_d  = alu_s;
            zero_d = (alu_s == {WIDTH{1'b0}});
            ovf_d  = alu_ovf_s;
        end else begin
            done_d = 1'b0;
        end
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            v1_q    <= 1'b0;
            op1_q   <= {OP_W{1'b0}};
            a1_q    <= {WIDTH{1'b0}};
            b1_q    <= {WIDTH{1'b0}};
            sh1_q   <= {SHAMT_W{1'b0}};
            done_q  <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            v1_q    <= v1_d;
            op1_q   <= op1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            sh1_q   <= sh1_d;
            done_q  <= done_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=16: the driver queues hand-computed
// results with the cycle they must appear in; a negedge monitor pops and compares on done.
module tb_alu_seq;

    localparam logic [3:0] T_AND = 4'd0,  T_OR  = 4'd1,  T_NOR = 4'd2,  T_ADD  = 4'd3;
    localparam logic [3:0] T_SLL = 4'd4,  T_SRL = 4'd5,  T_SUB = 4'd6,  T_SLT  = 4'd7;
    localparam logic [3:0] T_LUI = 4'd8,  T_SRA = 4'd9,  T_MUL = 4'd10, T_DIV  = 4'd11;
    localparam logic [3:0] T_MFHI = 4'd12, T_MFLO = 4'd13, T_NOP = 4'd14;

    localparam int K_DONE = 0, K_READY = 1, K_RES = 2, K_ZERO = 3, K_OVF = 4;
    localparam int K_HI = 5, K_LO = 6, K_SB32 = 7, K_SB16 = 8, K_READY16 = 9;

    typedef struct {
        string       nm;
        int          cyc;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] val;
    } probe_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start16;
    logic [3:0]  op32, op16;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic [4:0]  sh32;
    logic [3:0]  sh16;
    logic        ready32, done32, zero32, ovf32;
    logic [31:0] res32, hi32, lo32;
    logic        ready16, done16, zero16, ovf16;
    logic [15:0] res16, hi16, lo16;

    exp_t   sb32[$];
    exp_t   sb16[$];
    probe_t pq[$];
    exp_t   e_m;
    probe_t p_m;
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;

    alu_seq #(.WIDTH(32), .SHAMT_W(5), .OP_W(4)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUOperation(op32), .A(a32), .B(b32),
        .shamt(sh32), .ready(ready32), .done(done32), .ALUResult(res32), .Zero(zero32),
        .Overflow(ovf32), .HI(hi32), .LO(lo32)
    );

    alu_seq #(.WIDTH(16), .SHAMT_W(4), .OP_W(4)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .ALUOperation(op16), .A(a16), .B(b16),
        .shamt(sh16), .ready(ready16), .done(done16), .ALUResult(res16), .Zero(zero16),
        .Overflow(ovf16), .HI(hi16), .LO(lo16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] probe_val(input int kind);
        case (kind)
            K_DONE:    return {31'd0, done32};
            K_READY:   return {31'd0, ready32};
            K_RES:     return res32;
            K_ZERO:    return {31'd0, zero32};
            K_OVF:     return {31'd0, ovf32};
            K_HI:      return hi32;
            K_LO:      return lo32;
            K_SB32:    return 32'(sb32.size());
            K_SB16:    return 32'(sb16.size());
            K_READY16: return {31'd0, ready16};
            default:   return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        if (done32) begin
            if (sb32.size() == 0) begin
                chk("spurious_done32", {31'd0, done32}, 32'd0);
            end else begin
                e_m = sb32.pop_front();
                chk({e_m.nm, "_cycle"}, 32'(cyc), 32'(e_m.cyc));
                chk({e_m.nm, "_result"}, res32, e_m.res);
                chk({e_m.nm, "_zero"}, {31'd0, zero32}, {31'd0, e_m.zero});
                chk({e_m.nm, "_ovf"}, {31'd0, ovf32}, {31'd0, e_m.ovf});
                chk({e_m.nm, "_hi"}, hi32, e_m.hi);
                chk({e_m.nm, "_lo"}, lo32, e_m.lo);
            end
        end
        if (done16) begin
            if (sb16.size() == 0) begin
                chk("spurious_done16", {31'd0, done16}, 32'd0);
            end else begin
                e_m = sb16.pop_front();
                chk({e_m.nm, "_cycle"}, 32'(cyc), 32'(e_m.cyc));
                chk({e_m.nm, "_result"}, {16'd0, res16}, e_m.res);
                chk({e_m.nm, "_zero"}, {31'd0, zero16}, {31'd0, e_m.zero});
                chk({e_m.nm, "_ovf"}, {31'd0, ovf16}, {31'd0, e_m.ovf});
                chk({e_m.nm, "_hi"}, {16'd0, hi16}, e_m.hi);
                chk({e_m.nm, "_lo"}, {16'd0, lo16}, e_m.lo);
            end
        end
        while (pq.size() > 0) begin
            p_m = pq.pop_front();
            chk(p_m.nm, probe_val(p_m.kind), p_m.val);
        end
    end

    task automatic probe(input string nm, input int kind, input logic [31:0] val);
        probe_t p;
        p.nm   = nm;
        p.kind = kind;
        p.val  = val;
        pq.push_back(p);
    endtask

    // Present one op just after a rising edge; it is accepted on the next edge.
    task automatic issue(input bit w16, input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input bit push, input logic [31:0] res, input logic ovf,
                         input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        int   lat;
        @(posedge clk);
        #1;
        if (op == T_MUL || op == T_DIV) lat = w16 ? 18 : 34;
        else lat = 2;
        e.nm   = nm;
        e.cyc  = cyc + lat;
        e.res  = res;
        e.zero = (res == 32'd0);
        e.ovf  = ovf;
        e.hi   = hi;
        e.lo   = lo;
        start32 = 1'b0;
        start16 = 1'b0;
        if (w16) begin
            start16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; sh16 = sh[3:0];
            if (push) sb16.push_back(e);
        end else begin
            start32 = 1'b1; op32 = op; a32 = a; b32 = b; sh32 = sh;
            if (push) sb32.push_back(e);
        end
    endtask

    // Idle cycle; operands are scrambled to show in-flight ops ignore them.
    task automatic idle();
        @(posedge clk);
        #1;
        start32 = 1'b0;
        start16 = 1'b0;
        a32 = 32'hA5A5_5A5A; b32 = 32'h0000_0003; op32 = T_ADD; sh32 = 5'd7;
        a16 = 16'h1357;      b16 = 16'h0003;      op16 = T_ADD; sh16 = 4'd3;
    endtask

    initial begin
        reset = 1'b0;
        start32 = 1'b0; op32 = 4'd0; a32 = 32'd0; b32 = 32'd0; sh32 = 5'd0;
        start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; sh16 = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        probe("rst_done", K_DONE, 32'd0);
        probe("rst_result", K_RES, 32'd0);
        probe("rst_zero", K_ZERO, 32'd1);
        probe("rst_ovf", K_OVF, 32'd0);
        probe("rst_hi", K_HI, 32'd0);
        probe("rst_lo", K_LO, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        probe("rst_ready", K_READY, 32'd1);

        // Abort a multiply with reset a few cycles in: no done may ever follow.
        issue(1'b0, "mul_abort", T_MUL, 32'd7, 32'd9, 5'd0, 1'b0, 32'd63, 1'b0, 32'd0, 32'd63);
        repeat (4) idle();
        reset = 1'b0;
        idle();
        idle();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (i % 8 == 0) probe("abort_no_done", K_DONE, 32'd0);
        end
        probe("abort_ready", K_READY, 32'd1);
        probe("abort_hi", K_HI, 32'd0);
        probe("abort_lo", K_LO, 32'd0);
        probe("abort_result", K_RES, 32'd0);
        probe("abort_zero", K_ZERO, 32'd1);

        // Back-to-back single-cycle ops.
        issue(1'b0, "add_ovf", T_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 32'h8000_0000, 1'b1, 32'd0, 32'd0);
        issue(1'b0, "sub_zero", T_SUB, 32'd5, 32'd5, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "slt_neg", T_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "sra", T_SRA, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 32'hF800_0000, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "srl", T_SRL, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 32'h0800_0000, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "lui", T_LUI, 32'h0000_DEAD, 32'h0000_1234, 5'd0, 1'b1, 32'h1234_0000, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "and", T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1, 32'hF000_F000, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "or", T_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1, 32'hFFF0_FFF0, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "nor", T_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1, 32'h000F_000F, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "sll", T_SLL, 32'd1, 32'd0, 5'd31, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "sub_ovf", T_SUB, 32'h8000_0000, 32'd1, 5'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 32'd0, 32'd0);
        issue(1'b0, "add_wrap", T_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        issue(1'b0, "op14", T_NOP, 32'h1234_5678, 32'h1, 5'd3, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        idle();
        idle();

        // MULTU: ready low throughout, a start mid-op must be ignored.
        issue(1'b0, "multu", T_MUL, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFE);
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            start32 = (i == 10);
            op32 = T_ADD; a32 = 32'd1; b32 = 32'd1;
            if (i == 1 || i == 10 || i == 33) probe("multu_busy_ready", K_READY, 32'd0);
        end
        idle();
        probe("multu_ready_back", K_READY, 32'd1);

        // DIVU, HI/LO readback, divide by zero.
        issue(1'b0, "divu", T_DIV, 32'd100, 32'd7, 5'd0, 1'b1, 32'd14, 1'b0, 32'd2, 32'd14);
        repeat (34) idle();
        issue(1'b0, "mfhi", T_MFHI, 32'd0, 32'd0, 5'd0, 1'b1, 32'd2, 1'b0, 32'd2, 32'd14);
        issue(1'b0, "mflo", T_MFLO, 32'd0, 32'd0, 5'd0, 1'b1, 32'd14, 1'b0, 32'd2, 32'd14);
        issue(1'b0, "divu_by0", T_DIV, 32'd5, 32'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd5, 32'hFFFF_FFFF);
        repeat (34) idle();
        issue(1'b0, "mfhi_by0", T_MFHI, 32'd0, 32'd0, 5'd0, 1'b1, 32'd5, 1'b0, 32'd5, 32'hFFFF_FFFF);
        idle();

        // 16-bit instance.
        issue(1'b1, "multu16", T_MUL, 32'hFFFF, 32'hFFFF, 5'd0, 1'b1, 32'h0001, 1'b0, 32'hFFFE, 32'h0001);
        repeat (17) idle();
        issue(1'b1, "mfhi16", T_MFHI, 32'd0, 32'd0, 5'd0, 1'b1, 32'hFFFE, 1'b0, 32'hFFFE, 32'h0001);
        issue(1'b1, "mflo16", T_MFLO, 32'd0, 32'd0, 5'd0, 1'b1, 32'h0001, 1'b0, 32'hFFFE, 32'h0001);
        repeat (3) idle();
        probe("ready16_idle", K_READY16, 32'd1);
        probe("sb32_drained", K_SB32, 32'd0);
        probe("sb16_drained", K_SB16, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Executes single-cycle logic, shift, arithmetic and compare ops with a registered result.
- Adds iterative unsigned multiply and divide that write HI/LO registers, plus MFHI/MFLO reads.
- Sits in the EX stage. A start/ready/done handshake lets the control unit stall while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, datapath width in bits; even, at least 8.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).
- OP_W, 4, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; the op is accepted when start && ready.
- ALUOperation  input  OP_W  opcode, sampled at accept.
- A  input  WIDTH  operand A, sampled at accept.
- B  input  WIDTH  operand B, sampled at accept.
- shamt  input  SHAMT_W  shift amount, sampled at accept.
- ready  output  1  high when idle and able to accept an op.
- done  output  1  one-cycle pulse when a result is valid.
- ALUResult  output  WIDTH  registered result; holds until the next done.
- Zero  output  1  (ALUResult == 0); updated with ALUResult.
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (reset low, async):
  - FSM goes to IDLE; ready=1 once reset is released.
  - done, ALUResult, Overflow, HI and LO are 0; Zero=1.
  - Reset mid-multiply/divide aborts the op with no done pulse.
- Opcodes:
  - 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SLL, 5 SRL (logical), 6 SUB.
  - 7 SLT: signed; result 1 or 0, zero-extended.
  - 8 LUI: result = {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 9 SRA: arithmetic shift right.
  - 10 MULTU, 11 DIVU, 12 MFHI, 13 MFLO.
  - 14–15: result 0, single-cycle.
- Shifts use the shamt port, not B.
- ADD/SUB wrap modulo 2^WIDTH. Overflow is set when the operands' signs produce an impossible result sign.
- Single-cycle ops (everything except 10/11):
  - Accept at edge N; ALUResult, Zero, Overflow and done=1 are visible after edge N+1.
  - ready stays 1, so back-to-back issue gives throughput of one per cycle.
- MULTU:
  - Shift-add over WIDTH iterations.
  - ready=0 from the cycle after accept until done.
  - done pulses exactly WIDTH+1 cycles after accept.
  - {HI,LO} = A*B (2·WIDTH-bit product); ALUResult = new LO.
- DIVU:
  - Restoring division over WIDTH iterations, same latency and ready behaviour as MULTU.
  - LO = quotient, HI = remainder, ALUResult = quotient.
  - Divide by zero: LO = all ones, HI = A, same latency, no special flag.
- MFHI/MFLO return the HI/LO value current at accept. HI/LO are only changed by a completed MULTU/DIVU.
- FSM states:
  - IDLE: start with op 10 goes to MUL; start with op 11 goes to DIV; any other op stays in IDLE.
  - MUL/DIV: an iteration counter counts 0..WIDTH-1; at terminal count, write results, pulse done and return to IDLE.
- start while ready=0 is ignored; the op is not queued.
- done is 0 on every cycle without a new result. ALUResult, Zero and Overflow never change without done.
- Operands are latched at accept, so later changes on A/B/shamt/ALUOperation do not affect an in-flight op.

Decomposition:
- alu_pkg holds:
  - opcode localparams (AND..MFLO);
  - FSM state encoding (IDLE, MUL, DIV);
  - a DIV_BY_ZERO_LO constant (all ones).
- One sub-module, muldiv_iter, contains the shared iterative multiply/divide datapath:
  - inputs: start, is_div, A, B;
  - outputs: busy, fin, hi, lo.
- alu_seq keeps the single-cycle datapath, handshake and result registers.

Test Plan:
- Reset:
  - Assert reset mid-MULTU (A=7, B=9, cycle 5) → done never pulses.
  - After release: ready=1, HI=LO=0, ALUResult=0, Zero=1.
- Back-to-back single-cycle ops:
  - ADD 0x7FFFFFFF+1, then SUB 5-5, then SLT -1<1, on consecutive cycles.
  - Results: 0x80000000 with Overflow=1; then 0 with Zero=1; then 1.
  - done is high on three consecutive cycles.
- Shift and LUI:
  - SRA A=0x80000000, shamt=4 → 0xF8000000.
  - SRL same inputs → 0x08000000.
  - LUI B=0x1234 → 0x12340000.
- MULTU:
  - A=0xFFFFFFFF, B=2 → done exactly 33 cycles after accept; HI=1, LO=0xFFFFFFFE.
  - ready=0 throughout; a start issued mid-op is ignored.
- DIVU:
  - A=100, B=7 → LO=14, HI=2, ALUResult=14.
  - Then A=5, B=0 → LO=0xFFFFFFFF, HI=5, both after 33 cycles.
- HI/LO readback:
  - After the DIVU 100/7, MFHI → 2 and MFLO → 14, each single-cycle.
  - Repeat with WIDTH=16, SHAMT_W=4: MULTU 0xFFFF*0xFFFF → HI=0xFFFE, LO=0x0001, 17-cycle latency.
